svga_timing: RTL and testbench

Generates SVGA 800x600@60 raster timing from the 160 MHz PLL output. A divide-by-4 pixel clock-enable yields the 40 MHz pixel rate. The block gates all timing on a filtered PLL lock, so the raster starts only once the clock is stable and restarts cleanly if lock is lost. It sits directly downstream of the PLL and feeds the pixel/framebuffer pipeline.

---
 rtl/svga_pkg.sv | 39 +++
 rtl/pll_lock_filter.sv | 46 ++++
 rtl/svga_timing.sv | 213 +++++++++++++++++++++
 tb/tb_svga_timing.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svga_pkg.sv
// svga_pkg: SVGA 800x600@60 mode constants, FSM state type and shared helpers
// for the svga_timing block.
package svga_pkg;

    // Default mode: 800x600@60, 40 MHz pixel rate from a 160 MHz clock
    localparam int SVGA_CLK_DIV   = 4;
    localparam int SVGA_LOCK_WAIT = 1024;

    localparam int SVGA_H_ACTIVE  = 800;
    localparam int SVGA_H_FP      = 40;
    localparam int SVGA_H_SYNC    = 128;
    localparam int SVGA_H_BP      = 88;
    localparam int SVGA_H_TOTAL   = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;

    localparam int SVGA_V_ACTIVE  = 600;
    localparam int SVGA_V_FP      = 1;
    localparam int SVGA_V_SYNC    = 4;
    localparam int SVGA_V_BP      = 23;
    localparam int SVGA_V_TOTAL   = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

    localparam logic SVGA_H_SYNC_POL = 1'b1;
    localparam logic SVGA_V_SYNC_POL = 1'b1;

    // Position widths: H_TOTAL <= 2048, V_TOTAL <= 1024
    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } svga_state_e;

    // True when lo <= v < hi
    function automatic logic in_window(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// pll_lock_filter: brings the asynchronous PLL lock into the clock domain with a
// 2-flop synchronizer and counts consecutive synchronized-lock cycles. o_stable
// is asserted on the cycle in which the LOCK_WAIT-th consecutive lock cycle is
// seen, so the FSM can enter RUN on that same edge.
module pll_lock_filter #(
    parameter int LOCK_WAIT = 1024
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_locked,
    output logic o_lock_s,
    output logic o_stable
);

    localparam int CW = $clog2(LOCK_WAIT + 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;

    // Two-flop synchronizer for the asynchronous lock input
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_locked;
            r_sync <= r_meta;
        end
    end

    // Saturating count of consecutive synchronized-lock cycles; any drop clears it
    always_ff @(posedge i_clock) begin
        if (i_reset || !r_sync) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(LOCK_WAIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_lock_s = r_sync;
    assign o_stable = r_sync && (r_cnt >= CW'(LOCK_WAIT - 1));

endmodule

// File: rtl/svga_timing.sv
// svga_timing: SVGA raster timing generator gated on a filtered PLL lock.
// Optional feature macro: SVGA_TIMING_TESTPAT_EN adds o_rgb with 8 vertical
// colour bars across the active width.
// Every output changes only on clock edges; the pixel presented while
// o_pixel_ce is high is held for CLK_DIV cycles after each advance.
module svga_timing
    import svga_pkg::*;
#(
    parameter int   CLK_DIV    = SVGA_CLK_DIV,
    parameter int   LOCK_WAIT  = SVGA_LOCK_WAIT,
    parameter int   H_ACTIVE   = SVGA_H_ACTIVE,
    parameter int   H_FP       = SVGA_H_FP,
    parameter int   H_SYNC     = SVGA_H_SYNC,
    parameter int   H_BP       = SVGA_H_BP,
    parameter int   V_ACTIVE   = SVGA_V_ACTIVE,
    parameter int   V_FP       = SVGA_V_FP,
    parameter int   V_SYNC     = SVGA_V_SYNC,
    parameter int   V_BP       = SVGA_V_BP,
    parameter logic H_SYNC_POL = SVGA_H_SYNC_POL,
    parameter logic V_SYNC_POL = SVGA_V_SYNC_POL
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_locked,
    output logic           o_pixel_ce,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_active,
    output logic           o_frame_start,
`ifdef SVGA_TIMING_TESTPAT_EN
    output logic [2:0]     o_rgb,
`endif
    output logic           o_running
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic             w_lock_s;
    logic             w_stable;
    logic             w_load;
    logic             w_div_last;
    logic [X_W-1:0]   w_dec_x;
    logic [Y_W-1:0]   w_dec_y;
    logic             w_dec_hsync;
    logic             w_dec_vsync;
    logic             w_dec_active;

    svga_state_e      r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_pixel_ce;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;
    logic             r_frame_start;
    logic             r_running;

    pll_lock_filter #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_filter (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_locked (i_locked),
        .o_lock_s (w_lock_s),
        .o_stable (w_stable)
    );

    // Next pixel position and its decode; (0,0) is loaded on RUN entry
    always_comb begin
        w_load     = 1'b0;
        w_dec_x    = '0;
        w_dec_y    = '0;
        w_div_last = (r_div == DIV_W'(CLK_DIV - 1));
        if (r_state == RUN) begin
            w_load = r_pixel_ce;
            if (r_x == X_W'(H_TOTAL - 1)) begin
                w_dec_x = '0;
                if (r_y == Y_W'(V_TOTAL - 1)) begin
                    w_dec_y = '0;
                end else begin
                    w_dec_y = r_y + Y_W'(1);
                end
            end else begin
                w_dec_x = r_x + X_W'(1);
                w_dec_y = r_y;
            end
        end else begin
            w_load  = w_stable;
            w_dec_x = '0;
            w_dec_y = '0;
        end
        w_dec_hsync  = in_window(int'(w_dec_x), HS_START, HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
        w_dec_vsync  = in_window(int'(w_dec_y), VS_START, VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
        w_dec_active = (w_dec_x < X_W'(H_ACTIVE)) && (w_dec_y < Y_W'(V_ACTIVE));
    end

    // Lock-gated raster FSM with pixel divider and registered timing outputs
    always_ff @(posedge i_clock) begin
        if (i_reset || !w_lock_s) begin
            r_state       <= WAIT_LOCK;
            r_div         <= '0;
            r_pixel_ce    <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            case (r_state)
                WAIT_LOCK, SETTLE: begin
                    r_div         <= '0;
                    r_pixel_ce    <= 1'b0;
                    r_frame_start <= 1'b0;
                    if (w_stable) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_x       <= w_dec_x;
                        r_y       <= w_dec_y;
                        r_hsync   <= w_dec_hsync;
                        r_vsync   <= w_dec_vsync;
                        r_active  <= w_dec_active;
                    end else begin
                        r_state   <= SETTLE;
                        r_running <= 1'b0;
                    end
                end
                RUN: begin
                    r_state   <= RUN;
                    r_running <= 1'b1;
                    if (w_div_last) begin
                        r_div         <= '0;
                        r_pixel_ce    <= 1'b1;
                        r_frame_start <= (r_x == '0) && (r_y == '0);
                    end else begin
                        r_div         <= r_div + DIV_W'(1);
                        r_pixel_ce    <= 1'b0;
                        r_frame_start <= 1'b0;
                    end
                    if (w_load) begin
                        r_x      <= w_dec_x;
                        r_y      <= w_dec_y;
                        r_hsync  <= w_dec_hsync;
                        r_vsync  <= w_dec_vsync;
                        r_active <= w_dec_active;
                    end
                end
                default: begin
                    r_state       <= WAIT_LOCK;
                    r_div         <= '0;
                    r_pixel_ce    <= 1'b0;
                    r_x           <= '0;
                    r_y           <= '0;
                    r_hsync       <= ~H_SYNC_POL;
                    r_vsync       <= ~V_SYNC_POL;
                    r_active      <= 1'b0;
                    r_frame_start <= 1'b0;
                    r_running     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SVGA_TIMING_TESTPAT_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] w_dec_rgb;
    logic [2:0] r_rgb;

    // Colour-bar index of the next pixel; black outside the active area
    always_comb begin
        w_dec_rgb = 3'd0;
        if (w_dec_active) begin
            w_dec_rgb = 3'(w_dec_x / X_W'(BAR_W));
        end else begin
            w_dec_rgb = 3'd0;
        end
    end

    // Bar colour register, loaded together with the position registers
    always_ff @(posedge i_clock) begin
        if (i_reset || !w_lock_s) begin
            r_rgb <= 3'd0;
        end else if (w_load) begin
            r_rgb <= w_dec_rgb;
        end else begin
            r_rgb <= r_rgb;
        end
    end

    assign o_rgb = r_rgb;
`endif

    assign o_pixel_ce    = r_pixel_ce;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_active      = r_active;
    assign o_frame_start = r_frame_start;
    assign o_running     = r_running;

endmodule

// File: tb/tb_svga_timing.sv
// tb_svga_timing: two instances share clock/reset/lock. "m" is a reduced mode
// (active-low hsync) small enough to run whole frames; "f" is the default
// 800x600 mode, checked over its first line.
`timescale 1ns/1ps
module tb_svga_timing;

    localparam int CD = 4;
    localparam int LW = 16;
    localparam int HA = 80, HF = 4, HS = 12, HB = 8, HT = HA + HF + HS + HB;
    localparam int VA = 60, VF = 1, VS = 4, VB = 5, VT = VA + VF + VS + VB;
    localparam logic HP = 1'b0;
    localparam logic VP = 1'b1;
    localparam int FHA = 800, FHF = 40, FHS = 128, FHB = 88, FHT = FHA + FHF + FHS + FHB;

    logic clk = 1'b0;
    logic rst;
    logic locked;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        m_pixel_ce, m_hsync, m_vsync, m_active, m_frame_start, m_running;
    logic [10:0] m_x;
    logic [9:0]  m_y;
    logic [2:0]  m_rgb;
    logic        f_pixel_ce, f_hsync, f_vsync, f_active, f_frame_start, f_running;
    logic [10:0] f_x;
    logic [9:0]  f_y;
    logic [2:0]  f_rgb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    svga_timing #(
        .CLK_DIV(CD), .LOCK_WAIT(LW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(HP), .V_SYNC_POL(VP)
    ) dut_m (
        .i_clock(clk), .i_reset(rst), .i_locked(locked),
        .o_pixel_ce(m_pixel_ce), .o_x(m_x), .o_y(m_y),
        .o_hsync(m_hsync), .o_vsync(m_vsync), .o_active(m_active),
        .o_frame_start(m_frame_start),
`ifdef SVGA_TIMING_TESTPAT_EN
        .o_rgb(m_rgb),
`endif
        .o_running(m_running)
    );

    svga_timing #(
        .LOCK_WAIT(LW)
    ) dut_f (
        .i_clock(clk), .i_reset(rst), .i_locked(locked),
        .o_pixel_ce(f_pixel_ce), .o_x(f_x), .o_y(f_y),
        .o_hsync(f_hsync), .o_vsync(f_vsync), .o_active(f_active),
        .o_frame_start(f_frame_start),
`ifdef SVGA_TIMING_TESTPAT_EN
        .o_rgb(f_rgb),
`endif
        .o_running(f_running)
    );

`ifndef SVGA_TIMING_TESTPAT_EN
    assign m_rgb = 3'd0;
    assign f_rgb = 3'd0;
`endif

    logic [29:0] m_bus, f_bus;
    assign m_bus = {m_pixel_ce, m_x, m_y, m_hsync, m_vsync, m_active, m_frame_start, m_running, m_rgb};
    assign f_bus = {f_pixel_ce, f_x, f_y, f_hsync, f_vsync, f_active, f_frame_start, f_running, f_rgb};
    localparam logic [29:0] M_IDLE = {1'b0, 11'd0, 10'd0, ~HP, ~VP, 3'b000, 3'd0};
    localparam logic [29:0] F_IDLE = {1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 3'b000, 3'd0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        locked = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (m_bus !== M_IDLE) begin
                errors++;
                $display("FAIL reset_m cycle %0d got %h expected %h", i, m_bus, M_IDLE);
            end
            checks++;
            if (f_bus !== F_IDLE) begin
                errors++;
                $display("FAIL reset_f cycle %0d got %h expected %h", i, f_bus, F_IDLE);
            end
        end
        locked = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_lock_timing();
        int t0;
        locked = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 24) begin
            tick();
            if (cyc == t0 + 17) begin
                checks++;
                if ({m_running, f_running} !== 2'b00) begin
                    errors++;
                    $display("FAIL lock_run_early got %b expected 00", {m_running, f_running});
                end
            end
            if (cyc == t0 + 18) begin
                checks++;
                if ({m_running, f_running} !== 2'b11) begin
                    errors++;
                    $display("FAIL lock_run_entry got %b expected 11", {m_running, f_running});
                end
            end
            if (cyc == t0 + 21) begin
                checks++;
                if ({m_pixel_ce, f_pixel_ce} !== 2'b00) begin
                    errors++;
                    $display("FAIL first_ce_early got %b expected 00", {m_pixel_ce, f_pixel_ce});
                end
            end
            if (cyc == t0 + 22) begin
                checks++;
                if ({m_pixel_ce, m_x, m_y, m_frame_start, m_active} !== {1'b1, 11'd0, 10'd0, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL first_ce_m got ce=%b x=%0d y=%0d fs=%b act=%b expected 1,0,0,1,1",
                             m_pixel_ce, m_x, m_y, m_frame_start, m_active);
                end
                checks++;
                if ({f_pixel_ce, f_x, f_y, f_frame_start, f_active} !== {1'b1, 11'd0, 10'd0, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL first_ce_f got ce=%b x=%0d y=%0d fs=%b act=%b expected 1,0,0,1,1",
                             f_pixel_ce, f_x, f_y, f_frame_start, f_active);
                end
            end
        end
    endtask

    task automatic test_full_line();
        int p, last_ce, ex, ey, n_hs;
        logic eh, ea;
        logic [2:0] er;
        locked = 1'b0;
        repeat (6) tick();
        locked = 1'b1;
        p = 0; last_ce = -1; n_hs = 0;
        for (int c = 0; c < 40 + (FHT + 1) * CD && p <= FHT; c++) begin
            tick();
            if (f_pixel_ce === 1'b1) begin
                ex = p % FHT;
                ey = p / FHT;
                eh = (ex >= FHA + FHF) && (ex < FHA + FHF + FHS);
                ea = (ex < FHA);
                er = ea ? 3'(ex / (FHA / 8)) : 3'd0;
                checks++;
                if (f_x !== 11'(ex) || f_y !== 10'(ey)) begin
                    errors++;
                    $display("FAIL full_xy p=%0d got (%0d,%0d) expected (%0d,%0d)", p, f_x, f_y, ex, ey);
                end
                checks++;
                if ({f_hsync, f_vsync, f_active} !== {eh, 1'b0, ea}) begin
                    errors++;
                    $display("FAIL full_sync x=%0d got hs=%b vs=%b act=%b expected %b,0,%b",
                             ex, f_hsync, f_vsync, f_active, eh, ea);
                end
`ifdef SVGA_TIMING_TESTPAT_EN
                checks++;
                if (f_rgb !== er) begin
                    errors++;
                    $display("FAIL full_rgb x=%0d got %0d expected %0d", ex, f_rgb, er);
                end
`endif
                if (last_ce >= 0) begin
                    checks++;
                    if (cyc - last_ce != CD) begin
                        errors++;
                        $display("FAIL full_ce_period got %0d expected %0d", cyc - last_ce, CD);
                    end
                end
                if (f_hsync === 1'b1 && p < FHT) n_hs++;
                last_ce = cyc;
                p++;
            end
        end
        checks++;
        if (p != FHT + 1) begin
            errors++;
            $display("FAIL full_line_pixels got %0d expected %0d", p, FHT + 1);
        end
        checks++;
        if (n_hs != FHS) begin
            errors++;
            $display("FAIL full_hsync_width got %0d expected %0d", n_hs, FHS);
        end
    endtask

    task automatic test_lock_loss();
        int n, wait_ce, ph, t0, t1;
        for (int it = 0; it < 3; it++) begin
            wait_ce = $urandom_range(50, 400);
            ph = $urandom_range(0, CD - 1);
            n = 0;
            for (int c = 0; c < (wait_ce + 2) * CD && n < wait_ce; c++) begin
                tick();
                if (m_pixel_ce === 1'b1) n++;
            end
            repeat (ph) tick();
            locked = 1'b0;
            t0 = cyc;
            tick();
            tick();
            checks++;
            if (m_running !== 1'b1) begin
                errors++;
                $display("FAIL loss_sync_delay it=%0d got running=%b expected 1", it, m_running);
            end
            tick();
            checks++;
            if (m_bus !== M_IDLE) begin
                errors++;
                $display("FAIL loss_idle it=%0d got %h expected %h", it, m_bus, M_IDLE);
            end
            repeat (3) tick();
            locked = 1'b1;
            t1 = cyc;
            while (cyc < t1 + 22) begin
                tick();
                if (cyc == t1 + 17) begin
                    checks++;
                    if (m_running !== 1'b0) begin
                        errors++;
                        $display("FAIL relock_early it=%0d got %b expected 0", it, m_running);
                    end
                end
                if (cyc == t1 + 18) begin
                    checks++;
                    if (m_running !== 1'b1) begin
                        errors++;
                        $display("FAIL relock_run it=%0d got %b expected 1", it, m_running);
                    end
                end
            end
            checks++;
            if ({m_pixel_ce, m_x, m_y, m_frame_start} !== {1'b1, 11'd0, 10'd0, 1'b1}) begin
                errors++;
                $display("FAIL relock_origin it=%0d got ce=%b x=%0d y=%0d fs=%b expected 1,0,0,1",
                         it, m_pixel_ce, m_x, m_y, m_frame_start);
            end
        end
    endtask

    task automatic test_settle_glitch();
        int k, len, t0, r;
        for (int it = 0; it < 4; it++) begin
            k   = (it == 0) ? 12 : int'($urandom_range(3, 15));
            len = (it == 0) ? 2 : int'($urandom_range(1, 3));
            locked = 1'b0;
            repeat (5) tick();
            locked = 1'b1;
            t0 = cyc;
            while (cyc < t0 + k) tick();
            locked = 1'b0;
            repeat (len) tick();
            locked = 1'b1;
            r = cyc;
            while (cyc < r + 18) begin
                tick();
                checks++;
                if (m_running !== ((cyc == r + 18) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL settle_glitch k=%0d len=%0d at +%0d got running=%b", k, len, cyc - r, m_running);
                end
            end
        end
    endtask

    task automatic test_frame();
        int p, last_ce, q, ex, ey, n_act, n_fs, n_hs, n_vs;
        logic eh, ev, ea;
        logic [2:0] er;
        locked = 1'b0;
        repeat (4) tick();
        locked = 1'b1;
        p = 0; last_ce = -1; n_act = 0; n_fs = 0; n_hs = 0; n_vs = 0;
        for (int c = 0; c < 40 + (HT * VT + 1) * CD && p <= HT * VT; c++) begin
            tick();
            if (m_pixel_ce === 1'b1) begin
                q  = p % (HT * VT);
                ex = q % HT;
                ey = q / HT;
                eh = ((ex >= HA + HF) && (ex < HA + HF + HS)) ? HP : ~HP;
                ev = ((ey >= VA + VF) && (ey < VA + VF + VS)) ? VP : ~VP;
                ea = (ex < HA) && (ey < VA);
                er = ea ? 3'(ex / (HA / 8)) : 3'd0;
                checks++;
                if (m_x !== 11'(ex) || m_y !== 10'(ey)) begin
                    errors++;
                    $display("FAIL frame_xy p=%0d got (%0d,%0d) expected (%0d,%0d)", p, m_x, m_y, ex, ey);
                end
                checks++;
                if ({m_hsync, m_vsync, m_active, m_frame_start} !== {eh, ev, ea, (q == 0)}) begin
                    errors++;
                    $display("FAIL frame_decode (%0d,%0d) got hs=%b vs=%b act=%b fs=%b expected %b,%b,%b,%b",
                             ex, ey, m_hsync, m_vsync, m_active, m_frame_start, eh, ev, ea, (q == 0));
                end
`ifdef SVGA_TIMING_TESTPAT_EN
                checks++;
                if (m_rgb !== er) begin
                    errors++;
                    $display("FAIL frame_rgb (%0d,%0d) got %0d expected %0d", ex, ey, m_rgb, er);
                end
`endif
                if (last_ce >= 0) begin
                    checks++;
                    if (cyc - last_ce != CD) begin
                        errors++;
                        $display("FAIL frame_ce_period got %0d expected %0d", cyc - last_ce, CD);
                    end
                end
                if (p < HT * VT) begin
                    if (m_active === 1'b1) n_act++;
                    if (m_frame_start === 1'b1) n_fs++;
                    if (m_hsync === HP) n_hs++;
                    if (m_vsync === VP) n_vs++;
                end
                last_ce = cyc;
                p++;
            end
        end
        checks++;
        if (p != HT * VT + 1) begin
            errors++;
            $display("FAIL frame_pixels got %0d expected %0d", p, HT * VT + 1);
        end
        checks++;
        if (n_act != HA * VA) begin
            errors++;
            $display("FAIL frame_active_count got %0d expected %0d", n_act, HA * VA);
        end
        checks++;
        if (n_fs != 1) begin
            errors++;
            $display("FAIL frame_start_count got %0d expected 1", n_fs);
        end
        checks++;
        if (n_hs != HS * VT || n_vs != VS * HT) begin
            errors++;
            $display("FAIL frame_sync_counts got hs=%0d vs=%0d expected %0d,%0d", n_hs, n_vs, HS * VT, VS * HT);
        end
    endtask

    initial begin
        rst = 1'b1;
        locked = 1'b0;
        test_reset();
        test_lock_timing();
        test_full_line();
        test_lock_loss();
        test_settle_glitch();
        test_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
